// File: rtl/dot_acc_pkg.sv
// Shared definitions for the int8 dot-product accumulator datapath.
// Operand, product, accumulator and job-length widths live here so that the
// multiplier lanes and the accumulator agree on them. The optional product
// pipeline register is enabled in the top level by defining DOT_ACC_PIPE_EN.
package dot_acc_pkg;

  localparam int OP_W   = 8;   // signed operand width
  localparam int PROD_W = 16;  // full-precision signed product width
  localparam int ACC_W  = 23;  // accumulator width, matches the BF16 converter input
  localparam int LEN_W  = 8;   // job length width, up to 255 terms

  // DRAIN is only reachable when the product pipeline register is built in.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Sign-extend a full-precision product to accumulator width.
  function automatic logic [ACC_W-1:0] sext_prod(input logic [PROD_W-1:0] p);
    return {{(ACC_W - PROD_W){p[PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/int8_mul.sv
// Combinational signed 8x8 -> 16 multiplier, shared by the PE lanes.
// Both operands are sign-extended to the product width first so the low
// PROD_W bits of the product are the exact signed result.
module int8_mul
  import dot_acc_pkg::*;
(
  input  logic [OP_W-1:0]   a_i,
  input  logic [OP_W-1:0]   b_i,
  output logic [PROD_W-1:0] p_o
);

  logic [PROD_W-1:0] a_ext_s;
  logic [PROD_W-1:0] b_ext_s;

  assign a_ext_s = {{(PROD_W - OP_W){a_i[OP_W-1]}}, a_i};
  assign b_ext_s = {{(PROD_W - OP_W){b_i[OP_W-1]}}, b_i};
  assign p_o     = a_ext_s * b_ext_s;

endmodule

// File: rtl/int8_dot_accumulator.sv
// Signed int8 dot-product accumulator. A job is started with a term count,
// operand pairs are then streamed over a valid/ready handshake and their
// products summed into a 23-bit two's-complement accumulator. The sum is
// held on res_data with res_valid high until the consumer takes it.
// Define DOT_ACC_PIPE_EN to register the product before the adder; this adds
// a DRAIN state and one cycle of result latency without changing a_ready.
module int8_dot_accumulator
  import dot_acc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [OP_W-1:0]  a_data,
  input  logic [OP_W-1:0]  b_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             busy
);

  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W - 1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [PROD_W-1:0] prod_s;
  logic [ACC_W-1:0]  addend_s;
  logic              hs_s;

  int8_mul u_mul (
    .a_i (a_data),
    .b_i (b_data),
    .p_o (prod_s)
  );

  // An operand pair is consumed only while accumulating.
  assign hs_s = (state_q == ACC) && a_valid;

`ifdef DOT_ACC_PIPE_EN
  logic [PROD_W-1:0] pipe_q, pipe_d;

  // The adder sees the product registered in the previous cycle; the register
  // holds zero whenever no pair was accepted, so adding it is always safe.
  assign addend_s = sext_prod(pipe_q);
`else
  // The adder sees this cycle's product directly.
  assign addend_s = sext_prod(prod_s);
`endif

  // Next-state, accumulator and term-counter update.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
`ifdef DOT_ACC_PIPE_EN
    pipe_d  = '0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          rem_d   = len;
          state_d = (len != '0) ? ACC : DONE;
        end else begin
          state_d = IDLE;
        end
      end
      ACC: begin
`ifdef DOT_ACC_PIPE_EN
        acc_d = acc_q + addend_s;
        if (hs_s) begin
          pipe_d = prod_s;
          rem_d  = rem_q - LEN_ONE;
          if (rem_q == LEN_ONE) begin
            state_d = DRAIN;
          end else begin
            state_d = ACC;
          end
        end else begin
          state_d = ACC;
        end
`else
        if (hs_s) begin
          acc_d = acc_q + addend_s;
          rem_d = rem_q - LEN_ONE;
          if (rem_q == LEN_ONE) begin
            state_d = DONE;
          end else begin
            state_d = ACC;
          end
        end else begin
          state_d = ACC;
        end
`endif
      end
      DRAIN: begin
`ifdef DOT_ACC_PIPE_EN
        acc_d = acc_q + addend_s;
`endif
        state_d = DONE;
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, accumulator and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
    end
  end

`ifdef DOT_ACC_PIPE_EN
  // Product pipeline register; cleared on reset so an aborted job leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end
`endif

  // All outputs are decoded from registered state or taken from the accumulator.
  assign a_ready   = (state_q == ACC);
  assign res_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign res_data  = acc_q;

endmodule

// File: tb/tb_int8_dot_accumulator.sv
// Scoreboard bench for int8_dot_accumulator. Expected sums are pushed when a
// job is issued and popped by an independent monitor on every result
// handshake. Honours DOT_ACC_PIPE_EN for the result-latency checks.
module tb_int8_dot_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        a_valid;
  logic        a_ready;
  logic [7:0]  a_data;
  logic [7:0]  b_data;
  logic        res_valid;
  logic        res_ready;
  logic [22:0] res_data;
  logic        busy;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [22:0] exp_q[$];
  int          av[256];
  int          bv[256];
  int          idx      = 0;
  int          rdy_mode = 0;  // 0 random, 1 held low, 2 held high

  always #5 clk = ~clk;

  int8_dot_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_data    (a_data),
    .b_data    (b_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer dot product reduced modulo 2^23.
  function automatic logic [22:0] model(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += av[i] * bv[i];
    return 23'(s);
  endfunction

  // Result consumer.
  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        1: res_ready = 1'b0;
        2: res_ready = 1'b1;
        default: res_ready = ($urandom_range(3) != 0);
      endcase
    end
  end

  // Monitor: result handshakes against the scoreboard, plus hold stability.
  initial begin
    logic        pv;
    logic [22:0] pd;
    pv = 1'b0;
    pd = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (pv) begin
          check("hold_valid", res_valid, 1);
          check("hold_data", res_data, pd);
        end
        if (res_valid && res_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: got 0x%0h expected no result", res_data);
          end else begin
            check("res_data", res_data, exp_q.pop_front());
          end
        end
        pv = res_valid && !res_ready;
        pd = res_data;
      end else begin
        pv = 1'b0;
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (busy && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("idle_wait", busy, 0);
  endtask

  task automatic start_job(input int n, input logic [22:0] e);
    wait_idle();
    @(posedge clk);
    #1;
    start = 1'b1;
    len   = 8'(n);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("start_a_ready", a_ready, (n != 0));
    check("start_res_valid", res_valid, (n == 0));
    check("start_busy", busy, 1);
  endtask

  task automatic drive_beats(input int k, input int gap);
    int  done = 0;
    int  t    = 0;
    logic hs;
    @(posedge clk);
    #1;
    while (done < k && t < 4000) begin
      a_valid = ($urandom_range(99) >= gap);
      a_data  = 8'(av[idx]);
      b_data  = 8'(bv[idx]);
      @(negedge clk);
      hs = a_valid && a_ready;
      @(posedge clk);
      #1;
      if (hs) begin
        done++;
        idx++;
      end
      t++;
    end
    a_valid = 1'b0;
    check("beats_done", done, k);
  endtask

  task automatic check_last();
    @(negedge clk);
`ifdef DOT_ACC_PIPE_EN
    check("drain_res_valid", res_valid, 0);
    check("drain_busy", busy, 1);
    @(negedge clk);
`endif
    check("last_latency", res_valid, 1);
    check("last_a_ready", a_ready, 0);
  endtask

  task automatic run_job(input int n, input int gap, input logic [22:0] e);
    idx = 0;
    start_job(n, e);
    if (n != 0) begin
      drive_beats(n, gap);
      check_last();
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    rst = 1'b1; start = 1'b0; len = '0; a_valid = 1'b0; a_data = '0; b_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_ready", a_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Small known vector.
    for (int i = 0; i < 4; i++) begin av[i] = i + 1; bv[i] = i + 5; end
    run_job(4, 0, 23'd70);

    // Largest magnitude sum.
    for (int i = 0; i < 255; i++) begin av[i] = -128; bv[i] = -128; end
    run_job(255, 10, 23'h3FC000);

    // Extreme operand mix, negative result.
    av[0] = 127; bv[0] = -128; av[1] = -128; bv[1] = 127;
    run_job(2, 0, 23'h7F8100);

    // Empty job.
    run_job(0, 0, 23'd0);

    // Result held while consumer stalls; start in DONE and at hand-off is ignored.
    rdy_mode = 1;
    for (int i = 0; i < 3; i++) begin
      av[i] = int'($urandom_range(255)) - 128;
      bv[i] = int'($urandom_range(255)) - 128;
    end
    run_job(3, 50, model(3));
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      start = (c == 2);
      len   = 8'd9;
      @(negedge clk);
      check("done_busy", busy, 1);
      check("done_a_ready", a_ready, 0);
    end
    @(posedge clk);
    #1;
    rdy_mode = 2;
    start    = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    start    = 1'b0;
    rdy_mode = 0;
    @(negedge clk);
    check("handoff_busy", busy, 0);
    check("handoff_res_valid", res_valid, 0);
    @(negedge clk);
    check("handoff_no_job", a_ready, 0);

    // Reset mid-job discards the partial sum.
    for (int i = 0; i < 4; i++) begin
      av[i] = int'($urandom_range(255)) - 128;
      bv[i] = int'($urandom_range(255)) - 128;
    end
    idx = 0;
    start_job(4, model(4));
    drive_beats(2, 0);
    rst = 1'b1;
    void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_a_ready", a_ready, 0);
    check("midrst_res_valid", res_valid, 0);
    check("midrst_res_data", res_data, 0);
    check("midrst_busy", busy, 0);
    av[0] = -3; bv[0] = 7;
    run_job(1, 0, 23'h7FFFEB);

    // Random jobs against the reference sum.
    for (int j = 0; j < 25; j++) begin
      int n;
      n = $urandom_range(24);
      for (int i = 0; i < n; i++) begin
        av[i] = int'($urandom_range(255)) - 128;
        bv[i] = int'($urandom_range(255)) - 128;
      end
      run_job(n, 30, model(n));
    end

    rdy_mode = 2;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
